// File: rtl/fifo_mem_ctrl.sv
// rtl/fifo_mem_ctrl.sv - pointer, occupancy and flow-control controller for the FIFO storage memory
module fifo_mem_ctrl #(
    parameter int DEPTH     = 6,
    parameter int PTR_SIZE  = 6,
    parameter int AF_THRESH = 4,
    parameter int AE_THRESH = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [PTR_SIZE-1:0] af_thr_in,
    input  logic [PTR_SIZE-1:0] ae_thr_in,
    input  logic                push,
    input  logic                pop,
    output logic                mem_write,
    output logic                mem_read,
    output logic [PTR_SIZE-1:0] wr_ptr,
    output logic [PTR_SIZE-1:0] rd_ptr,
    output logic [PTR_SIZE-1:0] fifo_count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                error,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [PTR_SIZE-1:0] DEPTH_V = PTR_SIZE'(DEPTH);
    localparam logic [PTR_SIZE-1:0] LAST_V  = PTR_SIZE'(DEPTH - 1);
    localparam logic [PTR_SIZE-1:0] AF_DEF  = PTR_SIZE'(AF_THRESH);
    localparam logic [PTR_SIZE-1:0] AE_DEF  = PTR_SIZE'(AE_THRESH);
    localparam logic [PTR_SIZE-1:0] ONE     = PTR_SIZE'(1);

    state_t              cur_state, nxt_state;
    logic [PTR_SIZE-1:0] count_q, next_count, af_thr, ae_thr;
    logic                active, err_cyc, push_ok, pop_ok, thr_bad;

    assign active  = (cur_state == S_IDLE) || (cur_state == S_ACTIVE);
    // A cycle that overflows or underflows blocks both halves of the request.
    assign err_cyc = active && ((push && (count_q == DEPTH_V) && !pop) || (pop && (count_q == '0)));
    assign push_ok = active && !err_cyc && push && ((count_q < DEPTH_V) || pop);
    assign pop_ok  = active && !err_cyc && pop && (count_q != '0);
    assign thr_bad = (af_thr_in > DEPTH_V) || (af_thr_in == '0) || (ae_thr_in >= af_thr_in);

    assign mem_write    = push_ok;
    assign mem_read     = pop_ok;
    assign fifo_count   = count_q;
    assign full         = (count_q == DEPTH_V);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thr);
    assign almost_empty = (count_q <= ae_thr);
    assign state        = cur_state;

    always_comb begin
        next_count = count_q;
        if (push_ok && !pop_ok) begin
            next_count = count_q + ONE;
        end else if (pop_ok && !push_ok) begin
            next_count = count_q - ONE;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_RESET: nxt_state = S_INIT;
            S_INIT:  nxt_state = S_IDLE;
            S_IDLE: begin
                if (err_cyc) begin
                    nxt_state = S_ERROR;
                end else if (push_ok) begin
                    nxt_state = S_ACTIVE;
                end else if (init && !push) begin
                    nxt_state = S_INIT;
                end
            end
            S_ACTIVE: begin
                if (err_cyc) begin
                    nxt_state = S_ERROR;
                end else if ((next_count == '0) && !push_ok) begin
                    nxt_state = S_IDLE;
                end
            end
            S_ERROR: nxt_state = S_ERROR;
            default: nxt_state = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= S_RESET;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            error     <= 1'b0;
            af_thr    <= AF_DEF;
            ae_thr    <= AE_DEF;
        end else begin
            cur_state <= nxt_state;
            count_q   <= next_count;
            error     <= error || err_cyc;
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_V) ? '0 : wr_ptr + ONE;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_V) ? '0 : rd_ptr + ONE;
            end
            if (cur_state == S_INIT) begin
                af_thr <= thr_bad ? AF_DEF : af_thr_in;
                ae_thr <= thr_bad ? AE_DEF : ae_thr_in;
            end
        end
    end

endmodule
